// File: rtl/memory_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the backing-memory arbiter.
// slave is the arbiter's view; master is the view of the caches and RAM controller around it.
interface memory_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              halt;
    logic              i_ren;
    logic [ADDR_W-1:0] i_addr;
    logic              i_hit;
    logic [DATA_W-1:0] i_load;
    logic              d_ren;
    logic              d_wen;
    logic              d_atomic;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_store;
    logic              d_hit;
    logic [DATA_W-1:0] d_load;
    logic              ram_ren;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_store;
    logic [DATA_W-1:0] ram_load;
    logic              ram_ready;
    logic [1:0]        grant;

    modport slave (
        input  halt, i_ren, i_addr, d_ren, d_wen, d_atomic, d_addr, d_store,
               ram_load, ram_ready,
        output i_hit, i_load, d_hit, d_load, ram_ren, ram_wen, ram_addr,
               ram_store, grant
    );

    modport master (
        output halt, i_ren, i_addr, d_ren, d_wen, d_atomic, d_addr, d_store,
               ram_load, ram_ready,
        input  i_hit, i_load, d_hit, d_load, ram_ren, ram_wen, ram_addr,
               ram_store, grant
    );
endinterface

// File: rtl/memory_arbiter.sv
// Shares one backing-memory port between icache (read-only) and dcache (read/write/atomic),
// with data priority, bounded icache starvation, atomic-sequence locking and halt gating.
module memory_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               CLK,
    input  logic               RST,
    memory_arbiter_if.slave    bus
);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        I_ACC = 2'b01,
        D_ACC = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic               lock_q, lock_d;
    logic               d_req_c;
    logic               starved_c;

    assign d_req_c   = bus.d_ren | bus.d_wen;
    assign starved_c = (starve_q == CNT_W'(STARVE_LIMIT));
    assign bus.grant = 2'(state_q);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            starve_q <= '0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            lock_q   <= lock_d;
        end
    end

    // Arbitration, memory-port steering and completion handling.
    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        lock_d        = lock_q;
        bus.i_hit     = 1'b0;
        bus.i_load    = '0;
        bus.d_hit     = 1'b0;
        bus.d_load    = '0;
        bus.ram_ren   = 1'b0;
        bus.ram_wen   = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_store = '0;

        unique case (state_q)
            IDLE: begin
                if (!bus.d_atomic) begin
                    lock_d = 1'b0;
                end
                if (lock_q) begin
                    if (d_req_c) begin
                        state_d = D_ACC;
                        if (bus.i_ren && !starved_c) starve_d = starve_q + CNT_W'(1);
                    end
                end else if (starved_c && bus.i_ren && !bus.halt) begin
                    state_d  = I_ACC;
                    starve_d = '0;
                end else if (d_req_c) begin
                    state_d = D_ACC;
                    if (bus.i_ren && !starved_c) starve_d = starve_q + CNT_W'(1);
                end else if (bus.i_ren && !bus.halt) begin
                    state_d  = I_ACC;
                    starve_d = '0;
                end
            end

            I_ACC: begin
                bus.ram_ren  = 1'b1;
                bus.ram_addr = ADDR_W'(bus.i_addr);
                if (!bus.i_ren) begin
                    state_d = IDLE;
                end else if (bus.ram_ready) begin
                    bus.i_hit  = 1'b1;
                    bus.i_load = DATA_W'(bus.ram_load);
                    state_d    = IDLE;
                end
            end

            D_ACC: begin
                // Write wins when the dcache raises both strobes.
                if (bus.d_wen) begin
                    bus.ram_wen   = 1'b1;
                    bus.ram_store = DATA_W'(bus.d_store);
                end else begin
                    bus.ram_ren = 1'b1;
                end
                bus.ram_addr = ADDR_W'(bus.d_addr);
                if (!d_req_c) begin
                    state_d = IDLE;
                end else if (bus.ram_ready) begin
                    bus.d_hit  = 1'b1;
                    bus.d_load = DATA_W'(bus.ram_load);
                    lock_d     = bus.d_atomic;
                    state_d    = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: expected hits are queued when requests are issued
// and matched against the DUT's hit pulses as they appear.
module tb_memory_arbiter;
    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    memory_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_d, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        sb.push_back(e);
    endtask

    // Called right after a falling edge; returns at the sample point of the hit cycle.
    task automatic wait_hit(input string tag, input int max_cyc);
        exp_t e;
        bit   found = 1'b0;
        for (int n = 0; n < max_cyc && !found; n++) begin
            #1;
            if (bus.i_hit || bus.d_hit) found = 1'b1;
            else @(negedge CLK);
        end
        if (!found) begin
            tests++;
            fails++;
            $error("FAIL %s_timeout: observed no hit expected a hit within %0d cycles", tag, max_cyc);
        end else if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s_spurious: observed hit {i,d}=%b%b expected none", tag, bus.i_hit, bus.d_hit);
        end else begin
            e = sb.pop_front();
            check({tag, "_kind"}, 64'({bus.i_hit, bus.d_hit}), e.is_d ? 64'h1 : 64'h2);
            check({tag, "_load"}, 64'(e.is_d ? bus.d_load : bus.i_load), 64'(e.data));
            check({tag, "_other_load"}, 64'(e.is_d ? bus.i_load : bus.d_load), 64'h0);
        end
    endtask

    logic [1:0] starve_seq [6];

    initial begin
        RST           = 1'b1;
        bus.halt      = 1'b0;
        bus.i_ren     = 1'b0;
        bus.i_addr    = '0;
        bus.d_ren     = 1'b0;
        bus.d_wen     = 1'b0;
        bus.d_atomic  = 1'b0;
        bus.d_addr    = '0;
        bus.d_store   = '0;
        bus.ram_load  = '0;
        bus.ram_ready = 1'b0;
        starve_seq[0] = 2'b10; starve_seq[1] = 2'b10; starve_seq[2] = 2'b10;
        starve_seq[3] = 2'b10; starve_seq[4] = 2'b01; starve_seq[5] = 2'b10;

        // Reset idle
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("reset_idle", 64'({bus.grant, bus.i_hit, bus.d_hit, bus.ram_ren, bus.ram_wen,
                                     bus.ram_addr, bus.ram_store}), 64'h0);
            @(negedge CLK);
        end

        // Single icache read, ready two cycles after the strobe
        bus.i_ren    = 1'b1;
        bus.i_addr   = 32'h100;
        bus.ram_load = 32'hDEADBEEF;
        push(1'b0, 32'hDEADBEEF);
        #1 check("ird_req_grant", 64'(bus.grant), 64'h0);
        @(negedge CLK); #1;
        check("ird_ren", 64'(bus.ram_ren), 64'h1);
        check("ird_addr", 64'(bus.ram_addr), 64'h100);
        check("ird_grant", 64'(bus.grant), 64'h1);
        check("ird_no_early_hit", 64'(bus.i_hit), 64'h0);
        @(negedge CLK); #1 check("ird_wait_hit", 64'(bus.i_hit), 64'h0);
        @(negedge CLK);
        bus.ram_ready = 1'b1;
        wait_hit("ird", 1);
        @(negedge CLK);
        bus.i_ren = 1'b0;
        bus.ram_ready = 1'b0;
        #1 check("ird_back_idle", 64'({bus.grant, bus.ram_ren}), 64'h0);
        @(negedge CLK);

        // Contention and starvation bound
        bus.i_ren     = 1'b1;
        bus.i_addr    = 32'h180;
        bus.d_ren     = 1'b1;
        bus.d_addr    = 32'h20;
        bus.ram_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.ram_load = 32'hA5A5_0000 + 32'(k);
            push(starve_seq[k] == 2'b10, 32'hA5A5_0000 + 32'(k));
            wait_hit("starve", 4);
            check("starve_grant", 64'(bus.grant), 64'(starve_seq[k]));
            @(negedge CLK);
        end
        bus.i_ren = 1'b0;
        bus.d_ren = 1'b0;
        bus.ram_ready = 1'b0;
        @(negedge CLK);

        // Write priority over read
        bus.d_ren    = 1'b1;
        bus.d_wen    = 1'b1;
        bus.d_addr   = 32'h40;
        bus.d_store  = 32'h1234;
        bus.ram_load = 32'h55;
        @(negedge CLK); #1;
        check("wr_wen", 64'(bus.ram_wen), 64'h1);
        check("wr_ren", 64'(bus.ram_ren), 64'h0);
        check("wr_store", 64'(bus.ram_store), 64'h1234);
        check("wr_addr", 64'(bus.ram_addr), 64'h40);
        @(negedge CLK);
        bus.ram_ready = 1'b1;
        push(1'b1, 32'h55);
        wait_hit("wr", 1);
        @(negedge CLK);
        bus.d_ren = 1'b0;
        bus.d_wen = 1'b0;
        bus.ram_ready = 1'b0;
        @(negedge CLK);

        // Atomic lock holds off the icache until the SC completes
        bus.i_ren     = 1'b1;
        bus.i_addr    = 32'h200;
        bus.d_ren     = 1'b1;
        bus.d_atomic  = 1'b1;
        bus.d_addr    = 32'h80;
        bus.ram_ready = 1'b1;
        bus.ram_load  = 32'h11;
        push(1'b1, 32'h11);
        wait_hit("ll", 4);
        @(negedge CLK);
        bus.d_ren = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 check("lock_no_igrant", 64'({bus.grant, bus.i_hit}), 64'h0);
            @(negedge CLK);
        end
        bus.d_wen    = 1'b1;
        bus.d_atomic = 1'b0;
        bus.d_store  = 32'h22;
        bus.ram_load = 32'h22;
        push(1'b1, 32'h22);
        wait_hit("sc", 4);
        check("sc_grant", 64'(bus.grant), 64'h2);
        @(negedge CLK);
        bus.d_wen    = 1'b0;
        bus.ram_load = 32'h33;
        push(1'b0, 32'h33);
        wait_hit("post_sc_i", 4);
        check("post_sc_grant", 64'(bus.grant), 64'h1);
        @(negedge CLK);
        bus.i_ren = 1'b0;
        bus.ram_ready = 1'b0;

        // Halt blocks new icache grants
        bus.halt  = 1'b1;
        bus.i_ren = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            #1 check("halt_no_grant", 64'({bus.grant, bus.ram_ren}), 64'h0);
        end
        @(negedge CLK);
        bus.halt  = 1'b0;
        bus.i_ren = 1'b0;
        @(negedge CLK);

        // Abort: icache drops its request; a ready in the drop cycle is ignored
        bus.i_ren  = 1'b1;
        bus.i_addr = 32'h300;
        @(negedge CLK);
        #1 check("abort_grant", 64'(bus.grant), 64'h1);
        @(negedge CLK);
        bus.i_ren     = 1'b0;
        bus.ram_ready = 1'b1;
        #1 check("abort_no_hit", 64'(bus.i_hit), 64'h0);
        @(negedge CLK);
        bus.ram_ready = 1'b0;
        #1 check("abort_idle", 64'({bus.grant, bus.i_hit}), 64'h0);
        @(negedge CLK);

        // Reset during a dcache write drops it at once
        bus.d_wen   = 1'b1;
        bus.d_addr  = 32'h44;
        bus.d_store = 32'h99;
        @(negedge CLK);
        #1 check("rst_pre_wen", 64'(bus.ram_wen), 64'h1);
        RST = 1'b1;
        #1 check("rst_wen_drop", 64'({bus.ram_wen, bus.d_hit, bus.grant}), 64'h0);
        @(negedge CLK);
        RST = 1'b0;
        bus.d_wen = 1'b0;
        #1 check("rst_after", 64'({bus.grant, bus.d_hit, bus.ram_wen}), 64'h0);

        check("sb_drained", 64'(sb.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected $finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
